// File: rtl/ours_width_upsizer.sv
// ours_width_upsizer: valid/ready gather stage packing RATIO IN_WIDTH-bit beats into one word.
// Build option OURS_UPSIZER_ZERO_FILL_EN clears the accumulator on every completed word.
module ours_width_upsizer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      valid_in,
  output logic                      ready_out,
  input  logic [IN_WIDTH-1:0]       data_in,
  input  logic                      last_in,
  output logic                      valid_out,
  input  logic                      ready_in,
  output logic [IN_WIDTH*RATIO-1:0] data_out,
  output logic [RATIO-1:0]          mask_out,
  output logic                      last_out
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [OUT_WIDTH-1:0] acc, acc_nxt, merged;
  logic [RATIO-1:0]     acc_mask, acc_mask_nxt, lane_sel;
  logic                 accept, complete;

  // ready depends only on the output register and ready_in, never on valid_in/last_in
  assign ready_out = ~valid_out | ready_in;
  assign accept    = valid_in & ready_out;
  assign complete  = accept & ((idx == IDX_LAST) | last_in);

  always_comb begin
    lane_sel = '0;
    merged   = acc;
    for (int k = 0; k < RATIO; k++) begin
      if (idx == IDX_W'(k)) begin
        lane_sel[k] = 1'b1;
        merged[k*IN_WIDTH +: IN_WIDTH] = data_in;
      end
    end
  end

  always_comb begin
    idx_nxt      = idx;
    acc_nxt      = acc;
    acc_mask_nxt = acc_mask;
    if (accept) begin
      acc_nxt = merged;
      if (complete) begin
        idx_nxt      = '0;
        acc_mask_nxt = '0;
`ifdef OURS_UPSIZER_ZERO_FILL_EN
        acc_nxt      = '0;
`endif
      end else begin
        idx_nxt      = idx + IDX_W'(1);
        acc_mask_nxt = acc_mask | lane_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idx      <= '0;
      acc      <= '0;
      acc_mask <= '0;
    end else begin
      idx      <= idx_nxt;
      acc      <= acc_nxt;
      acc_mask <= acc_mask_nxt;
    end
  end

  // a completing beat may replace a word that is being drained in the same cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      mask_out  <= '0;
      last_out  <= 1'b0;
    end else if (complete) begin
      valid_out <= 1'b1;
      data_out  <= merged;
      mask_out  <= acc_mask | lane_sel;
      last_out  <= last_in;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ours_width_upsizer.sv
// Bench for ours_width_upsizer: queue-based reference model plus directed literal checks.
// Unfilled lanes are compared only when OURS_UPSIZER_ZERO_FILL_EN is defined.
module tb_ours_width_upsizer;

  logic        clk, rstn;
  logic        valid_in, ready_out, last_in, valid_out, ready_in, last_out;
  logic [7:0]  data_in;
  logic [31:0] data_out;
  logic [3:0]  mask_out;

  logic       v1, ro1, l1, vo1, r1in, lo1;
  logic [7:0] d1, do1;
  logic [0:0] mo1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ours_width_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .ready_out(ready_out),
    .data_in(data_in), .last_in(last_in), .valid_out(valid_out),
    .ready_in(ready_in), .data_out(data_out), .mask_out(mask_out),
    .last_out(last_out)
  );

  ours_width_upsizer #(.IN_WIDTH(8), .RATIO(1)) dut1 (
    .clk(clk), .rstn(rstn), .valid_in(v1), .ready_out(ro1),
    .data_in(d1), .last_in(l1), .valid_out(vo1),
    .ready_in(r1in), .data_out(do1), .mask_out(mo1),
    .last_out(lo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: collect beats, emit a word on the RATIO-th beat or on last
  logic [7:0]  cur[$];
  logic        m_valid = 1'b0, m_last = 1'b0, m_rdy;
  logic [31:0] m_data = '0;
  logic [3:0]  m_mask = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid = 1'b0; m_data = '0; m_mask = '0; m_last = 1'b0;
      cur.delete();
    end else begin
      m_rdy = !m_valid || ready_in;
      if (m_valid && ready_in) m_valid = 1'b0;
      if (valid_in && m_rdy) begin
        cur.push_back(data_in);
        if (cur.size() == 4 || last_in) begin
          m_data = '0; m_mask = '0;
          foreach (cur[i]) begin
            m_data[i*8 +: 8] = cur[i];
            m_mask[i] = 1'b1;
          end
          m_last = last_in; m_valid = 1'b1;
          cur.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] lm;
    if (rstn) begin
      chk("ready_out", 64'(ready_out), 64'(!m_valid || ready_in));
      chk("valid_out", 64'(valid_out), 64'(m_valid));
      if (m_valid) begin
`ifdef OURS_UPSIZER_ZERO_FILL_EN
        lm = '1;
`else
        for (int k = 0; k < 4; k++) lm[k*8 +: 8] = {8{m_mask[k]}};
`endif
        chk("mask_out", 64'(mask_out), 64'(m_mask));
        chk("last_out", 64'(last_out), 64'(m_last));
        chk("data_out", 64'(data_out & lm), 64'(m_data & lm));
      end
    end
  end

  logic [31:0] log_d[$];
  int          log_c[$];
  logic [7:0]  log1_d[$];
  logic [0:0]  log1_m[$];

  always @(negedge clk) begin
    if (rstn && valid_out && ready_in) begin
      log_d.push_back(data_out);
      log_c.push_back(cyc);
    end
    if (rstn && vo1 && r1in) begin
      log1_d.push_back(do1);
      log1_m.push_back(mo1);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l);
    logic r;
    int n;
    bit done;
    n = 0; done = 0;
    valid_in = 1'b1; data_in = d; last_in = l;
    while (!done) begin
      @(negedge clk); r = ready_out;
      @(posedge clk); #1;
      if (r) done = 1;
      else if (++n > 50) begin
        chk("send_timeout", 64'd0, 64'd1);
        done = 1;
      end
    end
  endtask

  task automatic wait_word();
    int n;
    n = 0;
    @(negedge clk);
    while (!valid_out && n < 20) begin
      @(negedge clk); n++;
    end
    chk("word_timeout", 64'(valid_out), 64'd1);
  endtask

  initial begin
    int sent;
    rstn = 1'b0; valid_in = 1'b0; data_in = '0; last_in = 1'b0; ready_in = 1'b1;
    v1 = 1'b0; d1 = '0; l1 = 1'b0; r1in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_mask", 64'(mask_out), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_last", 64'(last_out), 64'd0);
    chk("rst_ready", 64'(ready_out), 64'd1);
    @(negedge clk); #1 rstn = 1'b1;
    step();

    // full word
    send_beat(8'h11, 0); send_beat(8'h22, 0); send_beat(8'h33, 0); send_beat(8'h44, 1);
    idle();
    wait_word();
    chk("full_data", 64'(data_out), 64'h44332211);
    chk("full_mask", 64'(mask_out), 64'hF);
    chk("full_last", 64'(last_out), 64'd1);
    @(negedge clk);
    chk("full_one_cycle", 64'(valid_out), 64'd0);
    step();

    // partial word closed by last, then a fresh word starting at lane 0
    send_beat(8'hAA, 0); send_beat(8'hBB, 1);
    idle();
    wait_word();
`ifdef OURS_UPSIZER_ZERO_FILL_EN
    chk("part_data", 64'(data_out), 64'h0000BBAA);
`else
    chk("part_data", 64'(data_out[15:0]), 64'hBBAA);
`endif
    chk("part_mask", 64'(mask_out), 64'h3);
    chk("part_last", 64'(last_out), 64'd1);
    step();
    send_beat(8'hCC, 1);
    idle();
    wait_word();
    chk("lane0_mask", 64'(mask_out), 64'h1);
    chk("lane0_data", 64'(data_out[7:0]), 64'hCC);
    step();

    // backpressure
    ready_in = 1'b0;
    send_beat(8'h01, 0); send_beat(8'h02, 0); send_beat(8'h03, 0); send_beat(8'h04, 0);
    valid_in = 1'b1; data_in = 8'h10; last_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_ready", 64'(ready_out), 64'd0);
      chk("bp_valid", 64'(valid_out), 64'd1);
      chk("bp_data", 64'(data_out), 64'h04030201);
      chk("bp_mask", 64'(mask_out), 64'hF);
      step();
    end
    ready_in = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(ready_out), 64'd1);
    step();
    idle();
    send_beat(8'h20, 0); send_beat(8'h30, 1);
    idle();
    wait_word();
    chk("bp_next_mask", 64'(mask_out), 64'h7);
    chk("bp_next_data", 64'(data_out[23:0]), 64'h302010);
    step();

    // streaming
    log_d.delete(); log_c.delete();
    for (int i = 1; i <= 8; i++) send_beat(8'(i), 0);
    idle();
    repeat (3) step();
    chk("stream_count", 64'(log_d.size()), 64'd2);
    if (log_d.size() == 2) begin
      chk("stream_w0", 64'(log_d[0]), 64'h04030201);
      chk("stream_w1", 64'(log_d[1]), 64'h08070605);
      chk("stream_gap", 64'(log_c[1] - log_c[0]), 64'd4);
    end

    // async reset while a word is held
    ready_in = 1'b0;
    send_beat(8'hA1, 0); send_beat(8'hA2, 0); send_beat(8'hA3, 0); send_beat(8'hA4, 0);
    idle();
    step();
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_out), 64'd0);
    chk("arst_mask", 64'(mask_out), 64'd0);
    chk("arst_data", 64'(data_out), 64'd0);
    @(negedge clk); #1 rstn = 1'b1;
    ready_in = 1'b1;
    step();

    // async reset mid-word discards the partial word
    send_beat(8'h55, 0); send_beat(8'h66, 0);
    idle();
    step();
    #2 rstn = 1'b0;
    #1;
    chk("mrst_valid", 64'(valid_out), 64'd0);
    chk("mrst_mask", 64'(mask_out), 64'd0);
    @(negedge clk); #1 rstn = 1'b1;
    step();
    send_beat(8'h01, 0); send_beat(8'h02, 0); send_beat(8'h03, 0); send_beat(8'h04, 0);
    idle();
    wait_word();
    chk("mrst_data", 64'(data_out), 64'h04030201);
    chk("mrst_full_mask", 64'(mask_out), 64'hF);
    step();

    // RATIO=1 instance with toggling downstream ready
    sent = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      r1in = (c % 3 != 1);
      v1 = (sent < 2);
      d1 = (sent == 0) ? 8'h07 : 8'h09;
      @(negedge clk);
      if (v1 && ro1) sent++;
    end
    step();
    v1 = 1'b0; r1in = 1'b1;
    repeat (2) step();
    chk("r1_count", 64'(log1_d.size()), 64'd2);
    if (log1_d.size() == 2) begin
      chk("r1_w0", 64'(log1_d[0]), 64'h07);
      chk("r1_w1", 64'(log1_d[1]), 64'h09);
      chk("r1_m0", 64'(log1_m[0]), 64'h1);
      chk("r1_m1", 64'(log1_m[1]), 64'h1);
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step();
      valid_in = ($urandom_range(0, 9) < 7);
      data_in  = 8'($urandom);
      last_in  = ($urandom_range(0, 3) == 0);
      ready_in = ($urandom_range(0, 9) < 6);
    end
    step();
    idle();
    ready_in = 1'b1;
    repeat (4) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
